transmitter_my: RTL and testbench

TRANSMITTER_MY -- requirements
Module: transmitter_my

---
 rtl/transmitter_my_if.sv | 28 ++
 rtl/transmitter_my.sv | 161 ++++++++++++++++
 tb/tb_transmitter_my.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/transmitter_my_if.sv
// Byte-in / serial-out handshake bundle for transmitter_my.
// master drives tx_start/tx_data; slave (the transmitter) drives the line and status.
interface transmitter_my_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx,
    input  tx_ready,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx,
    output tx_ready,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/transmitter_my.sv
// UART transmitter with a one-entry holding register, oversampled bit timing, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the eighth data bit.
module transmitter_my #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_tick,
  transmitter_my_if.slave  bus
);

  localparam int unsigned    TW       = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  TickLast = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]     StopLast = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE_S,
    START_S,
    DATA_S,
`ifdef UART_TX_PARITY_EN
    PARITY_S,
`endif
    STOP_S
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [7:0]      shift_q, shift_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            load;
  logic            tick_end;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign tick_end = br_tick && (tick_q == TickLast);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    done_d      = 1'b0;
    load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    if (bus.tx_start && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    // Ticks only count while a frame is on the line.
    if (state_q != IDLE_S && br_tick) begin
      tick_d = tick_end ? '0 : tick_q + 1'b1;
    end

    unique case (state_q)
      IDLE_S: begin
        if (hold_full_q) load = 1'b1;
      end
      START_S: begin
        if (tick_end) state_d = DATA_S;
      end
      DATA_S: begin
        if (tick_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY_S;
`else
            state_d = STOP_S;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_S: begin
        if (tick_end) state_d = STOP_S;
      end
`endif
      STOP_S: begin
        if (tick_end) begin
          if (bit_q == StopLast) begin
            done_d = 1'b1;
            bit_d  = 3'd0;
            // Back-to-back frames reload on the done edge with no idle gap.
            if (hold_full_q) load = 1'b1;
            else             state_d = IDLE_S;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE_S;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      tick_d      = '0;
      bit_d       = 3'd0;
      state_d     = START_S;
`ifdef UART_TX_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end

    unique case (state_d)
      START_S:  tx_d = 1'b0;
      DATA_S:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY_S: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE_S;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      tick_q      <= '0;
      bit_q       <= 3'd0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = ~hold_full_q;
  assign bus.tx_busy  = (state_q != IDLE_S);
  assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_transmitter_my.sv
// Bench for transmitter_my: frame-timeline model checked every cycle on instance A,
// plus directed literal checks on A and on a slow-tick, two-stop-bit instance B.
module tb_transmitter_my;
  localparam int OVS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_A = (10 + PAR) * OVS;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick_a = 1'b1;
  logic tick_b = 1'b0;
  always #5 clk = ~clk;

  transmitter_my_if bus_a ();
  transmitter_my_if bus_b ();

  transmitter_my #(.OVERSAMPLE(16), .STOP_BITS(1)) u_dut_a (
    .clk     (clk),
    .reset   (reset),
    .br_tick (tick_a),
    .bus     (bus_a)
  );

  transmitter_my #(.OVERSAMPLE(16), .STOP_BITS(2)) u_dut_b (
    .clk     (clk),
    .reset   (reset),
    .br_tick (tick_b),
    .bus     (bus_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a frame is a list of line bits, each held for OVS ticks after the load edge.
  logic        m_active = 1'b0;
  logic        m_hold_full = 1'b0;
  logic        m_done = 1'b0;
  logic [7:0]  m_hold = 8'h00;
  logic [10:0] m_bits = '1;
  int          m_pos = 0;

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (PAR == 1) f[9] = ^d;
    return f;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0; m_hold_full = 1'b0; m_done = 1'b0; m_pos = 0;
    end else begin
      m_done = 1'b0;
      if (m_active && tick_a) begin
        m_pos++;
        if (m_pos == FRAME_A) begin
          m_done = 1'b1;
          m_active = 1'b0;
        end
      end
      if (!m_active && m_hold_full) begin
        m_bits = frame_of(m_hold);
        m_active = 1'b1;
        m_pos = 0;
        m_hold_full = 1'b0;
      end else if (bus_a.tx_start && !m_hold_full) begin
        m_hold = bus_a.tx_data;
        m_hold_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("tx_cycle", 32'(bus_a.tx), m_active ? 32'(m_bits[m_pos / OVS]) : 32'd1);
      check("tx_ready_cycle", 32'(bus_a.tx_ready), 32'(!m_hold_full));
      check("tx_busy_cycle", 32'(bus_a.tx_busy), 32'(m_active));
      check("tx_done_cycle", 32'(bus_a.tx_done), 32'(m_done));
    end
  end

  // Independent line receiver on A, sampling mid-bit.
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte = 8'h00;
  int         rx_ph = 0;
  int         done_cnt = 0;
  always @(negedge clk) begin
    int off;
    if (reset) begin
      rx_ph = 0;
    end else begin
      if (bus_a.tx_done) done_cnt++;
      if (rx_ph == 0) begin
        if (bus_a.tx == 1'b0) rx_ph = 1;
      end else begin
        off = rx_ph;
        rx_ph++;
        if (off >= 24 && off <= 136 && (off - 8) % 16 == 0) rx_byte[(off - 24) / 16] = bus_a.tx;
        if (off == 8 + 16 * (9 + PAR)) begin
          rx_q.push_back(rx_byte);
          rx_ph = 0;
        end
      end
    end
  end

  task automatic send_a(input logic [7:0] d);
    @(negedge clk);
    bus_a.tx_start = 1'b1;
    bus_a.tx_data  = d;
    @(negedge clk);
    bus_a.tx_start = 1'b0;
  endtask

  task automatic wait_fall_a(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus_a.tx === 1'b0) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_done_a(input string name, input int limit, output int j);
    j = -1;
    for (int i = 1; i <= limit && j < 0; i++) begin
      @(negedge clk);
      if (bus_a.tx_done === 1'b1) j = i;
    end
    check(name, 32'(j > 0), 32'd1);
  endtask

  initial begin
    logic [9:0] pat;
    int dj, jd, dsave, rsave;
    int low_cnt, rise, done_at, dcnt;
    bus_a.tx_start = 1'b0; bus_a.tx_data = 8'h00;
    bus_b.tx_start = 1'b0; bus_b.tx_data = 8'h00;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus_a.tx), 32'd1);
    check("rst_ready", 32'(bus_a.tx_ready), 32'd1);
    check("rst_busy", 32'(bus_a.tx_busy), 32'd0);
    check("rst_done", 32'(bus_a.tx_done), 32'd0);
    check("rst_b_tx", 32'(bus_b.tx), 32'd1);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0x55: mid-bit pattern and done spacing.
    send_a(8'h55);
    wait_fall_a("start_55");
    pat = 10'b1010101010;
    dj = -1;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      if (j % 16 == 8 && j <= 8 + 16 * 8) check("bit_55", 32'(bus_a.tx), 32'(pat[j / 16]));
      if (bus_a.tx_done === 1'b1 && dj < 0) dj = j;
    end
    check("done_spacing_55", dj, FRAME_A);
    check("rx_55", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'h55);

    // Back-to-back 0xA3 / 0x0F with a rejected 0xFF.
    send_a(8'hA3);
    wait_fall_a("start_a3");
    repeat (40) @(negedge clk);
    check("ready_before_0f", 32'(bus_a.tx_ready), 32'd1);
    send_a(8'h0F);
    check("ready_after_0f", 32'(bus_a.tx_ready), 32'd0);
    send_a(8'hFF);
    wait_done_a("done_a3", 200, jd);
    check("b2b_start_on_done", 32'(bus_a.tx), 32'd0);
    check("b2b_ready_on_done", 32'(bus_a.tx_ready), 32'd1);
    wait_done_a("done_0f", 200, jd);
    repeat (200) @(negedge clk);
    check("rx_count_b2b", rx_q.size(), 3);
    check("rx_a3", 32'(rx_q.size() > 1 ? rx_q[1] : 8'hxx), 32'hA3);
    check("rx_0f", 32'(rx_q.size() > 2 ? rx_q[2] : 8'hxx), 32'h0F);
    check("done_count_b2b", done_cnt, 3);

    // tx_start held across the load edge: the second byte must be dropped.
    @(negedge clk);
    bus_a.tx_start = 1'b1; bus_a.tx_data = 8'h3C;
    @(negedge clk);
    bus_a.tx_data = 8'hC3;
    @(negedge clk);
    bus_a.tx_start = 1'b0;
    wait_done_a("done_3c", 200, jd);
    repeat (200) @(negedge clk);
    check("rx_count_load_edge", rx_q.size(), 4);
    check("rx_3c", 32'(rx_q.size() > 3 ? rx_q[3] : 8'hxx), 32'h3C);
    check("idle_after_3c", 32'(bus_a.tx_busy), 32'd0);

`ifdef UART_TX_PARITY_EN
    send_a(8'h07);
    wait_fall_a("start_07");
    dj = -1;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      if (j == 8 + 16 * 9) check("parity_07", 32'(bus_a.tx), 32'd1);
      if (bus_a.tx_done === 1'b1 && dj < 0) dj = j;
    end
    check("frame_len_07", dj, 176);
    send_a(8'h03);
    wait_fall_a("start_03");
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      if (j == 8 + 16 * 9) check("parity_03", 32'(bus_a.tx), 32'd0);
    end
`endif

    // Reset mid-frame with a byte held.
    send_a(8'h81);
    wait_fall_a("start_81");
    repeat (5) @(negedge clk);
    send_a(8'h42);
    check("ready_held_42", 32'(bus_a.tx_ready), 32'd0);
    repeat (33) @(negedge clk);
    dsave = done_cnt;
    rsave = rx_q.size();
    #1 reset = 1'b1;
    #1;
    check("abort_tx", 32'(bus_a.tx), 32'd1);
    check("abort_ready", 32'(bus_a.tx_ready), 32'd1);
    check("abort_busy", 32'(bus_a.tx_busy), 32'd0);
    check("abort_done", 32'(bus_a.tx_done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("abort_no_done", done_cnt, dsave);
    check("abort_no_frame", rx_q.size(), rsave);
    check("abort_idle_busy", 32'(bus_a.tx_busy), 32'd0);

    // Instance B: tick every 4th clk, two stop bits, 0x00.
    low_cnt = 0; rise = -1; done_at = -1; dcnt = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (bus_b.tx === 1'b0) low_cnt++;
      else if (low_cnt > 0 && rise < 0) rise = i;
      if (bus_b.tx_done === 1'b1) begin
        dcnt++;
        if (done_at < 0) done_at = i;
      end
      tick_b = (i % 4 == 1);
      bus_b.tx_start = (i == 0);
      bus_b.tx_data = 8'h00;
    end
    tick_b = 1'b0;
    check("b_low_clks", low_cnt, (9 + PAR) * 64);
    check("b_stop_clks", done_at - rise, 128);
    check("b_done_count", dcnt, 1);
    check("b_idle_ready", 32'(bus_b.tx_ready), 32'd1);
    check("b_idle_busy", 32'(bus_b.tx_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
